// File: rtl/serial_adder_n.sv
// serial_adder_n
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, with a
// carry flop linking consecutive bits. Operands are handed over through a
// start/busy/done handshake; sum and carry_out are registered and only
// change on the edge that enters DONE.

module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] acc_shift;
    logic             load;

    // Single full-adder slice on the LSBs, and the sum register shifted with the new bit in its MSB
    always_comb begin
        bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        acc_shift = acc_q >> 1;
        acc_shift[WIDTH-1] = bit_s;
    end

    // Sequencing: IDLE waits for start, ADD consumes one bit per cycle, DONE publishes the result
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            S_ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_shift;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = acc_shift;
                    cout_d  = bit_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = carry_in;
            cnt_d   = '0;
            state_d = S_ADD;
        end
    end

    // State and datapath registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q == S_ADD);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n
// Exercises three instances of the serial adder (WIDTH 8, 1 and 16) sharing
// one clock and reset. Expected sums are pushed to a per-width queue when an
// operation is started and popped when that instance raises done.

module tb_serial_adder_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0;
    logic [0:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1;
    logic        done1;
    logic [0:0]  sum1;
    logic        cout1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int total = 0;
    int bad = 0;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];

    logic [8:0]  last8 = '0;

    // Free-running 100 MHz clock shared by all three instances
    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    serial_adder_n #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    serial_adder_n #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16)
    );

    // Advance past one rising edge; inputs are driven and outputs sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected 8-bit result and present start for exactly one edge
    task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
        a8 = av;
        b8 = bv;
        cin8 = cv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
    endtask

    // Wait (bounded) for done on the 8-bit instance, counting edges since acceptance and busy cycles
    task automatic wait_done8(output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = (busy8 === 1'b1) ? 1 : 0;
        while (done8 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            if (busy8 === 1'b1) busy_cnt++;
        end
    endtask

    // Reset held for two edges with start asserted must leave every instance idle and cleared
    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b1;  a8 = 8'($urandom);   b8 = 8'($urandom);
        start1 = 1'b1;  a1 = 1'b1;           b1 = 1'b1;
        start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
        tick();
        tick();
        total++;
        if ({busy8, done8} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_busy_done8: got %b expected 00", {busy8, done8});
        end
        total++;
        if ({cout8, sum8} !== 9'h000) begin
            bad++;
            $display("[TB] FAIL reset_sum8: got %h expected 000", {cout8, sum8});
        end
        total++;
        if ({busy1, done1, cout1, sum1} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_w1: got %b expected 0000", {busy1, done1, cout1, sum1});
        end
        total++;
        if ({busy16, done16, cout16, sum16} !== 19'h0) begin
            bad++;
            $display("[TB] FAIL reset_w16: got %h expected 0", {busy16, done16, cout16, sum16});
        end
        start8 = 1'b0;
        start1 = 1'b0;
        start16 = 1'b0;
        rst = 1'b0;
        tick();
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle8: got busy=%b expected 0", busy8);
        end
    endtask

    // Reference operation: latency, busy length, result and single-cycle done
    task automatic test_basic8();
        int edges;
        int busy_cnt;
        logic [8:0] exp;
        start_op8(8'hA5, 8'h3C, 1'b0);
        wait_done8(edges, busy_cnt);
        total++;
        if (edges !== 8) begin
            bad++;
            $display("[TB] FAIL basic_latency: got %0d edges expected 8", edges);
        end
        total++;
        if (busy_cnt !== 8) begin
            bad++;
            $display("[TB] FAIL basic_busy_len: got %0d cycles expected 8", busy_cnt);
        end
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy_in_done: got busy=%b expected 0", busy8);
        end
        exp = q8.pop_front();
        last8 = exp;
        total++;
        if ({cout8, sum8} !== exp || exp !== 9'h0E1) begin
            bad++;
            $display("[TB] FAIL basic_sum: got %h expected %h", {cout8, sum8}, exp);
        end
        tick();
        total++;
        if (done8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_done_pulse: got done=%b expected 0", done8);
        end
    endtask

    // Full-length carry ripple cases
    task automatic test_carry8();
        logic [7:0] ta[2] = '{8'hFF, 8'hFF};
        logic [7:0] tb[2] = '{8'h01, 8'hFF};
        logic       tc[2] = '{1'b0, 1'b1};
        int edges;
        int busy_cnt;
        logic [8:0] exp;
        for (int i = 0; i < 2; i++) begin
            start_op8(ta[i], tb[i], tc[i]);
            wait_done8(edges, busy_cnt);
            total++;
            if (edges !== 8) begin
                bad++;
                $display("[TB] FAIL carry_latency[%0d]: got %0d expected 8", i, edges);
            end
            exp = q8.pop_front();
            last8 = exp;
            total++;
            if ({cout8, sum8} !== exp) begin
                bad++;
                $display("[TB] FAIL carry_sum[%0d]: got %h expected %h", i, {cout8, sum8}, exp);
            end
            tick();
        end
    endtask

    // start held high with changing operands: first capture wins and outputs hold until the new DONE
    task automatic test_start_held8();
        int edges;
        logic [8:0] exp;
        q8.push_back(9'h012 + 9'h034 + 9'h001);
        a8 = 8'h12;
        b8 = 8'h34;
        cin8 = 1'b1;
        start8 = 1'b1;
        tick();
        edges = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            total++;
            if ({cout8, sum8} !== last8) begin
                bad++;
                $display("[TB] FAIL hold_sum@%0d: got %h expected %h", edges, {cout8, sum8}, last8);
            end
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            tick();
            edges++;
        end
        start8 = 1'b0;
        total++;
        if (edges !== 8) begin
            bad++;
            $display("[TB] FAIL hold_latency: got %0d expected 8", edges);
        end
        exp = q8.pop_front();
        last8 = exp;
        total++;
        if ({cout8, sum8} !== exp) begin
            bad++;
            $display("[TB] FAIL hold_sum: got %h expected %h", {cout8, sum8}, exp);
        end
        tick();
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_idle: got busy=%b expected 0", busy8);
        end
    endtask

    // start in the DONE cycle is accepted straight into ADD without an IDLE cycle
    task automatic test_back_to_back8();
        int edges;
        int busy_cnt;
        logic [8:0] exp;
        start_op8(8'h10, 8'h20, 1'b0);
        wait_done8(edges, busy_cnt);
        exp = q8.pop_front();
        total++;
        if (done8 !== 1'b1 || {cout8, sum8} !== exp) begin
            bad++;
            $display("[TB] FAIL b2b_first: got done=%b sum=%h expected done=1 sum=%h", done8, {cout8, sum8}, exp);
        end
        start_op8(8'h01, 8'h02, 1'b0);
        total++;
        if (busy8 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_no_idle: got busy=%b expected 1", busy8);
        end
        wait_done8(edges, busy_cnt);
        total++;
        if (edges !== 8) begin
            bad++;
            $display("[TB] FAIL b2b_latency: got %0d expected 8", edges);
        end
        exp = q8.pop_front();
        last8 = exp;
        total++;
        if ({cout8, sum8} !== exp) begin
            bad++;
            $display("[TB] FAIL b2b_second: got %h expected %h", {cout8, sum8}, exp);
        end
        tick();
    endtask

    // Reset during the fourth ADD cycle aborts the operation and clears the outputs
    task automatic test_abort8();
        logic seen_done;
        a8 = 8'h55;
        b8 = 8'h66;
        cin8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            bad++;
            $display("[TB] FAIL abort_clear: got %h expected 000", {busy8, done8, cout8, sum8});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: got activity=%b expected 0", seen_done);
        end
    endtask

    // WIDTH=1 behaves as a registered full adder over all eight input combinations
    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] exp;
        int edges;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            q1.push_back({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
            a1 = v[2];
            b1 = v[1];
            cin1 = v[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            edges = 0;
            while (done1 !== 1'b1 && edges < 10) begin
                tick();
                edges++;
            end
            total++;
            if (edges !== 1) begin
                bad++;
                $display("[TB] FAIL w1_latency[%0d]: got %0d expected 1", i, edges);
            end
            exp = q1.pop_front();
            total++;
            if ({cout1, sum1} !== exp) begin
                bad++;
                $display("[TB] FAIL w1_sum[%0d]: got %b expected %b", i, {cout1, sum1}, exp);
            end
            tick();
        end
    endtask

    // WIDTH=16 random operands, each new start issued in the previous DONE cycle
    task automatic test_random16();
        logic [15:0] av;
        logic [15:0] bv;
        logic        cv;
        logic [16:0] exp;
        int edges;
        for (int n = 0; n < 1000; n++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            cv = 1'($urandom);
            q16.push_back({1'b0, av} + {1'b0, bv} + {16'd0, cv});
            a16 = av;
            b16 = bv;
            cin16 = cv;
            start16 = 1'b1;
            tick();
            start16 = 1'b0;
            edges = 0;
            while (done16 !== 1'b1 && edges < 60) begin
                tick();
                edges++;
            end
            total++;
            if (edges !== 16) begin
                bad++;
                $display("[TB] FAIL r16_latency[%0d]: got %0d expected 16", n, edges);
            end
            exp = q16.pop_front();
            total++;
            if ({cout16, sum16} !== exp) begin
                bad++;
                $display("[TB] FAIL r16_sum[%0d]: got %h expected %h", n, {cout16, sum16}, exp);
            end
        end
        tick();
    endtask

    // Run every scenario in order, then print the summary
    initial begin
        test_reset();
        test_basic8();
        test_carry8();
        test_start_held8();
        test_back_to_back8();
        test_abort8();
        test_width1();
        test_random16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock. A single full-adder slice is reused across cycles, and a carry flip-flop links each bit to the next. It replaces a WIDTH-wide combinational adder where area matters more than latency. A start/busy/done handshake hands it operands from a controller.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only when busy == 0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- carry_in  input  1  carry into bit 0; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse when sum and carry_out become valid.
- sum  output  WIDTH  registered result (a + b + carry_in) mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- State machine with three states: IDLE, ADD, DONE.
- IDLE:
  - busy = 0, done = 0.
  - On start = 1: load a, b and carry_in into internal shift registers and the carry flip-flop; clear the bit counter; go to ADD.
- ADD:
  - busy = 1.
  - Each cycle computes s = a_sh[0] ^ b_sh[0] ^ c and c' = majority(a_sh[0], b_sh[0], c).
  - Shift a_sh and b_sh right by one.
  - Shift s into the MSB of the internal sum shift register.
  - c <= c'; counter increments.
  - After WIDTH ADD cycles (counter == WIDTH-1 on the current edge), go to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - sum and carry_out are updated from the internal registers on the edge that enters DONE.
  - Next state is IDLE. If start = 1 during the DONE cycle, it is accepted: load operands and go directly to ADD.
- Output holding:
  - sum and carry_out change only on the edge entering DONE.
  - They hold their value through IDLE and through any later ADD until the next DONE.
- start while busy = 1 is ignored; operands in flight are unaffected.
- a, b and carry_in are don't-care except on the accepting edge.
- Arithmetic:
  - {carry_out, sum} equals the WIDTH+1-bit value a + b + carry_in.
  - The counter is $clog2(WIDTH+1) bits wide; no wrap occurs within an operation.
- WIDTH = 1 must work: one ADD cycle, which is functionally a registered full adder.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, carry_out 0. Internal shift registers, carry and counter are cleared.
- rst has priority over start and over all state transitions.
- rst asserted mid-ADD aborts the operation: no done pulse, and outputs are forced to their reset values on that edge.
- Cycle timing, with start accepted on edge E:
  - busy = 1 after edges E through E+WIDTH-1.
  - The edge E+WIDTH enters DONE: done = 1 and sum/carry_out are valid for the cycle after E+WIDTH.
  - Latency from the accepting edge to the done-rising edge is WIDTH cycles.
  - Total occupancy is WIDTH+1 cycles; back-to-back throughput is one result per WIDTH+1 cycles.
- done is never high in two consecutive cycles.
- busy and done are never high together.

## Test plan
- Reset check: assert rst for 2 cycles with start = 1 and random a, b -> busy = 0, done = 0, sum = 0x00, carry_out = 0. No operation starts while rst = 1.
- WIDTH = 8:
  - a = 0xA5, b = 0x3C, carry_in = 0 -> done pulses exactly 8 edges after the accepting edge; sum = 0xE1, carry_out = 0. busy is high for exactly 8 cycles.
  - Carry propagation: a = 0xFF, b = 0x01, carry_in = 0 -> sum = 0x00, carry_out = 1.
  - Carry propagation: a = 0xFF, b = 0xFF, carry_in = 1 -> sum = 0xFF, carry_out = 1.
  - Start ignored / output hold: hold start = 1 through the whole ADD phase with changing a, b -> the result matches the operands captured on the first edge. sum holds its previous value until the new DONE.
  - Back-to-back and abort: start = 1 in the DONE cycle with a = 0x01, b = 0x02 -> the next result is 0x03, with no IDLE cycle between. Separately, rst mid-ADD (cycle 4) -> no done pulse, sum = 0x00, carry_out = 0, state IDLE.
- WIDTH = 1: exhaustive over all 8 combinations of a, b, carry_in -> {carry_out, sum} matches the full-adder truth table, with done 1 edge after acceptance.
- WIDTH = 16: 1000 random operands -> each {carry_out, sum} equals the 17-bit a + b + carry_in.
